// File: rtl/tm1637_frame_sequencer.sv
// Drives one complete TM1637 display update (data command, address + digits, display control)
// through a byte-level transmitter using a valid/ready/done handshake, with per-frame NACK retry.
module tm1637_frame_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_RETRY  = 2
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    upd_req,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_first,
  output logic                    tx_last,
  input  logic                    tx_ready,
  input  logic                    tx_done,
  input  logic                    tx_nack
);

  typedef enum logic [2:0] {IDLE, F1, F2A, F2D, F3, WAIT, GAP} state_t;

  state_t                  state;
  state_t                  frame;
  logic                    pending;
  logic [7:0]              retry_cnt;
  logic [2:0]              idx;
  logic [2:0]              next_idx;
  logic [7:0]              gap_cnt;
  logic [8*NUM_DIGITS-1:0] seg_snap;
  logic [2:0]              bright_snap;
  logic                    on_snap;

  // Returns {first, last, data} for the byte a given offer state presents.
  function automatic logic [9:0] offer(input state_t s, input logic [2:0] i,
                                       input logic [8*NUM_DIGITS-1:0] seg,
                                       input logic disp, input logic [2:0] br);
    logic [9:0] r;
    r = '0;
    case (s)
      F1:  r = {1'b1, 1'b1, 8'h40};
      F2A: r = {1'b1, 1'b0, 8'hC0};
      F2D: begin
        r[9]   = 1'b0;
        r[8]   = (int'(i) == NUM_DIGITS - 1);
        r[7:0] = 8'(seg >> {i, 3'b000});
      end
      F3:      r = {1'b1, 1'b1, 4'h8, disp, br};
      default: r = '0;
    endcase
    return r;
  endfunction

  // The address byte is the only non-last byte with first set, so it leaves idx at 0.
  always_comb begin
    next_idx = tx_first ? idx : idx + 3'd1;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame       <= F1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      tx_first    <= 1'b0;
      tx_last     <= 1'b0;
      pending     <= 1'b0;
      retry_cnt   <= 8'd0;
      idx         <= 3'd0;
      gap_cnt     <= 8'd0;
      seg_snap    <= '0;
      bright_snap <= 3'd0;
      on_snap     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && upd_req) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (upd_req || pending) begin
            seg_snap    <= seg_data;
            bright_snap <= brightness;
            on_snap     <= display_on;
            error       <= 1'b0;
            busy        <= 1'b1;
            pending     <= 1'b0;
            retry_cnt   <= 8'd0;
            idx         <= 3'd0;
            frame       <= F1;
            state       <= F1;
            tx_valid    <= 1'b1;
            {tx_first, tx_last, tx_data} <= offer(F1, 3'd0, seg_data, display_on, brightness);
          end
        end

        // Offer states hold the byte registered on entry until the transmitter takes it.
        F1, F2A, F2D, F3: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (tx_done) begin
            if (tx_nack) begin
              if (int'(retry_cnt) < MAX_RETRY) begin
                retry_cnt <= retry_cnt + 8'd1;
                gap_cnt   <= 8'd0;
                state     <= GAP;
              end else begin
                error   <= 1'b1;
                busy    <= 1'b0;
                pending <= 1'b0;
                state   <= IDLE;
              end
            end else if (!tx_last) begin
              idx      <= next_idx;
              tx_valid <= 1'b1;
              {tx_first, tx_last, tx_data} <= offer(F2D, next_idx, seg_snap, on_snap, bright_snap);
              state    <= F2D;
            end else begin
              case (frame)
                F1: begin
                  frame     <= F2A;
                  retry_cnt <= 8'd0;
                  gap_cnt   <= 8'd0;
                  state     <= GAP;
                end
                F2A: begin
                  frame     <= F3;
                  retry_cnt <= 8'd0;
                  gap_cnt   <= 8'd0;
                  state     <= GAP;
                end
                default: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              endcase
            end
          end
        end

        // frame holds the first state of the frame to (re)start after the gap.
        GAP: begin
          if (int'(gap_cnt) == GAP_CYCLES - 1) begin
            gap_cnt  <= 8'd0;
            idx      <= 3'd0;
            tx_valid <= 1'b1;
            {tx_first, tx_last, tx_data} <= offer(frame, 3'd0, seg_snap, on_snap, bright_snap);
            state    <= frame;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
